// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: slot prescaler, hex decode, per-digit enable/dot/blink,
// leading-zero blanking, PWM brightness and frame-synchronous shadow loading.
module seg_scan_display #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 5000,
  parameter int BLINK_FRAMES = 50,
  parameter int BRIGHT_W     = 3
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   digit_val,
  input  logic [DIGITS-1:0]     dot,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_blank,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  load,
  output logic                  pending,
  output logic                  frame_start,
  output logic [7:0]            HEX,
  output logic [DIGITS-1:0]     AN
);

  localparam int PW  = $clog2(SCAN_DIV);
  localparam int SW  = $clog2(DIGITS);
  localparam int FW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int OTW = BRIGHT_W + 1 + $clog2(SCAN_DIV + 1);

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(DIGITS - 1);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] p;
  logic [SW-1:0] s;
  logic [FW-1:0] fc;
  logic          bp;

  logic [DIGITS-1:0][3:0] sh_val;
  logic [DIGITS-1:0]      sh_dot;
  logic [DIGITS-1:0]      sh_en;
  logic [DIGITS-1:0]      sh_blink;

  logic              slot_end;
  logic              boundary;
  logic [DIGITS-1:0] zero_run;
  logic              lz_hit;
  logic [OTW-1:0]    on_full;
  logic [OTW-1:0]    on_time;
  logic              visible;
  logic [3:0]        cur_val;
  logic [DIGITS-1:0] an_next;
  logic [7:0]        hex_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0:    seg_decode = 7'b1000000;
      4'h1:    seg_decode = 7'b1111001;
      4'h2:    seg_decode = 7'b0100100;
      4'h3:    seg_decode = 7'b0110000;
      4'h4:    seg_decode = 7'b0011001;
      4'h5:    seg_decode = 7'b0010010;
      4'h6:    seg_decode = 7'b0000010;
      4'h7:    seg_decode = 7'b1111000;
      4'h8:    seg_decode = 7'b0000000;
      4'h9:    seg_decode = 7'b0010000;
      4'hA:    seg_decode = 7'b0001000;
      4'hB:    seg_decode = 7'b0000011;
      4'hC:    seg_decode = 7'b1000110;
      4'hD:    seg_decode = 7'b0100001;
      4'hE:    seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  assign slot_end = (p == P_LAST);
  assign boundary = slot_end && (s == S_LAST);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      p  <= '0;
      s  <= '0;
      fc <= '0;
      bp <= 1'b0;
    end else begin
      if (slot_end) begin
        p <= '0;
        s <= (s == S_LAST) ? '0 : s + SW'(1);
      end else begin
        p <= p + PW'(1);
      end
      if (boundary) begin
        if (fc == F_LAST) begin
          fc <= '0;
          bp <= ~bp;
        end else begin
          fc <= fc + FW'(1);
        end
      end
    end
  end

  // A load on the boundary edge itself is taken directly, so pending never rises for it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pending     <= 1'b0;
      frame_start <= 1'b0;
      sh_val      <= '0;
      sh_dot      <= '0;
      sh_en       <= '0;
      sh_blink    <= '0;
    end else begin
      frame_start <= boundary;
      if (boundary) begin
        pending <= 1'b0;
        if (pending || load) begin
          sh_val   <= digit_val;
          sh_dot   <= dot;
          sh_en    <= digit_en;
          sh_blink <= blink;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // zero_run[i]: shadow nibbles i..DIGITS-1 are all zero.
  always_comb begin
    logic acc;
    acc      = 1'b1;
    zero_run = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc         = acc & (sh_val[i] == 4'h0);
      zero_run[i] = acc;
    end
  end

  assign on_full = (OTW'(bright) + OTW'(1)) * OTW'(SCAN_DIV);
  assign on_time = on_full >> BRIGHT_W;

  assign cur_val = sh_val[s];
  assign lz_hit  = lz_blank && (s != '0) && zero_run[s];
  assign visible = sh_en[s] && !lz_hit && !(sh_blink[s] && bp) && (OTW'(p) < on_time);

  always_comb begin
    an_next  = '1;
    hex_next = 8'hFF;
    if (visible) begin
      an_next[s] = 1'b0;
      hex_next   = {~sh_dot[s], seg_decode(cur_val)};
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      AN  <= '1;
      HEX <= 8'hFF;
    end else begin
      AN  <= an_next;
      HEX <= hex_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (4 digits, 4 clocks/slot, 2 frames/blink half, 2-bit bright).
module tb_seg_scan_display;

  logic        clock = 1'b0;
  logic        rst;
  logic [15:0] digit_val;
  logic [3:0]  dot;
  logic [3:0]  digit_en;
  logic [3:0]  blink;
  logic        lz_blank;
  logic [1:0]  bright;
  logic        load;
  logic        pending;
  logic        frame_start;
  logic [7:0]  HEX;
  logic [3:0]  AN;

  int checks = 0;
  int errors = 0;

  seg_scan_display #(
    .DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .BRIGHT_W(2)
  ) dut (
    .clock(clock), .rst(rst), .digit_val(digit_val), .dot(dot), .digit_en(digit_en),
    .blink(blink), .lz_blank(lz_blank), .bright(bright), .load(load),
    .pending(pending), .frame_start(frame_start), .HEX(HEX), .AN(AN)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge where frame_start is high; checks the next 16 cycles.
  // hx holds the lit HEX byte per digit (digit 0 in bits 7:0), lit the digits expected visible.
  task automatic check_frame(input string tag, input logic [31:0] hx, input logic [3:0] lit,
                             input int on_t);
    for (int k = 0; k < 16; k++) begin
      int d;
      int pp;
      logic vis;
      logic [3:0] ea;
      logic [7:0] eh;
      tick(1);
      d   = k / 4;
      pp  = k % 4;
      vis = lit[d] && (pp < on_t);
      ea  = vis ? ~(4'b0001 << d) : 4'hF;
      eh  = vis ? hx[8*d +: 8] : 8'hFF;
      chk({tag, "_an"}, 32'(AN), 32'(ea));
      chk({tag, "_hex"}, 32'(HEX), 32'(eh));
      chk({tag, "_fs"}, 32'(frame_start), (k == 15) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic sync_frame(input string tag);
    for (int i = 0; i < 40 && frame_start !== 1'b1; i++) tick(1);
    chk({tag, "_sync"}, 32'(frame_start), 32'd1);
    chk({tag, "_pend_clr"}, 32'(pending), 32'd0);
  endtask

  task automatic load_and_sync(input string tag);
    load = 1'b1;
    tick(1);
    load = 1'b0;
    chk({tag, "_pend_set"}, 32'(pending), 32'd1);
    sync_frame(tag);
  endtask

  initial begin
    rst       = 1'b0;
    digit_val = 16'h0000;
    dot       = 4'h0;
    digit_en  = 4'h0;
    blink     = 4'h0;
    lz_blank  = 1'b0;
    bright    = 2'd3;
    load      = 1'b0;
    tick(3);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_hex", 32'(HEX), 32'hFF);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    rst = 1'b1;

    // Blank display, frame_start every 16 cycles after release.
    for (int n = 1; n <= 32; n++) begin
      tick(1);
      chk("idle_an", 32'(AN), 32'hF);
      chk("idle_hex", 32'(HEX), 32'hFF);
      chk("idle_pend", 32'(pending), 32'd0);
      chk("idle_fs", 32'(frame_start), (n % 16 == 0) ? 32'd1 : 32'd0);
    end

    digit_val = 16'h1234;
    digit_en  = 4'hF;
    dot       = 4'b0100;
    bright    = 2'd3;
    load_and_sync("ld1234");
    check_frame("full", 32'hF924B099, 4'hF, 4);

    bright = 2'd0;
    check_frame("dim", 32'hF924B099, 4'hF, 1);

    bright = 2'd3;
    blink  = 4'b0010;
    load_and_sync("ldblink");
    check_frame("blink_off0", 32'hF924B099, 4'b1101, 4);
    check_frame("blink_off1", 32'hF924B099, 4'b1101, 4);
    check_frame("blink_on0", 32'hF924B099, 4'hF, 4);
    check_frame("blink_on1", 32'hF924B099, 4'hF, 4);

    blink     = 4'h0;
    dot       = 4'h0;
    lz_blank  = 1'b1;
    digit_val = 16'h0050;
    load_and_sync("ld0050");
    check_frame("lz0050", 32'hFFFF92C0, 4'b0011, 4);

    digit_val = 16'h0000;
    load_and_sync("ld0000");
    check_frame("lz0000", 32'hFFFFFFC0, 4'b0001, 4);

    digit_val = 16'h9999;
    check_frame("noload", 32'hFFFFFFC0, 4'b0001, 4);

    tick(4);
    lz_blank  = 1'b0;
    digit_val = 16'hC0DE;
    load_and_sync("ld_s1");
    check_frame("c0de", 32'hC6C0A186, 4'hF, 4);

    load = 1'b1;
    tick(1);
    load = 1'b0;
    tick(7);
    chk("pre_rst_pend", 32'(pending), 32'd1);
    chk("pre_rst_an", 32'(AN), 32'hD);
    chk("pre_rst_hex", 32'(HEX), 32'hA1);
    rst = 1'b0;
    #1;
    chk("async_rst_an", 32'(AN), 32'hF);
    chk("async_rst_hex", 32'(HEX), 32'hFF);
    chk("async_rst_pend", 32'(pending), 32'd0);
    chk("async_rst_fs", 32'(frame_start), 32'd0);
    tick(2);
    rst = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick(1);
      chk("post_rst_an", 32'(AN), 32'hF);
      chk("post_rst_hex", 32'(HEX), 32'hFF);
      chk("post_rst_fs", 32'(frame_start), (n == 16) ? 32'd1 : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
